ifetch16: RTL and testbench
===========================

IFETCH16 -- requirements
Module: ifetch16

Interface
REQ-001 Parameter RESET_PC, default 8'h00: fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 2: instruction-buffer entries; only value 2 is supported.
REQ-003 CK  input  1: single clock; all state changes on rising edge.
REQ-004 RST_N  input  1: reset, asynchronous, active-low.
REQ-005 mem_req  output  1: byte read request to instruction memory.
REQ-006 mem_addr  output  8: byte address of the current request.
REQ-007 mem_ack  input  1: memory has returned mem_rdata for the current request this cycle.
REQ-008 mem_rdata  input  8: read byte, valid only when mem_ack=1.
REQ-009 redir_valid  input  1: one-cycle request to restart fetch at redir_pc (branch/jump).
REQ-010 redir_pc  input  8: new fetch byte address; any value, including odd, is legal.
REQ-011 ir_valid  output  1: ir/ir_pc hold a valid instruction for the decode/execute stage.
REQ-012 ir  output  16: assembled instruction word.
REQ-013 ir_pc  output  8: byte address of the instruction's low byte.
REQ-014 ir_ready  input  1: downstream accepts ir this cycle; transfer occurs when ir_valid and ir_ready are both 1.

Function
REQ-015 The block SHALL read each 16-bit instruction as two byte reads: low byte at PC, then high byte at PC+1, forming ir = {mem[PC+1], mem[PC]}.
REQ-016 The FSM SHALL have states IDLE, FETCH_LO and FETCH_HI.
REQ-017 IDLE -> FETCH_LO SHALL occur when the buffer count is less than 2; otherwise the FSM stays in IDLE.
REQ-018 FETCH_LO -> FETCH_HI SHALL occur on mem_ack, capturing mem_rdata as the low byte and incrementing the fetch address by 1.
REQ-019 FETCH_HI -> FETCH_LO or IDLE (per the REQ-017 rule) SHALL occur on mem_ack, pushing {rdata, low byte} with its PC into the buffer and incrementing the fetch address by 1.
REQ-020 mem_req SHALL be 1 in FETCH_LO and FETCH_HI and SHALL stay at 1 until mem_ack arrives; mem_addr SHALL be stable while mem_req=1 and mem_ack=0.
REQ-021 mem_ack may arrive in the same cycle as mem_req rises (zero-wait memory); any number of wait cycles SHALL be tolerated.
REQ-022 mem_ack received outside FETCH_LO/FETCH_HI SHALL be ignored.
REQ-023 The fetch address SHALL be 8 bits wide and wrap 8'hFF -> 8'h00, including between the low and high byte of a single instruction.
REQ-024 The buffer SHALL be a 2-entry FIFO; ir, ir_pc and ir_valid SHALL come from the head entry, registered, with no combinational path from mem_rdata.
REQ-025 A push and a pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-026 Since a fetch starts only when count<2, a push SHALL never occur when count=2.
REQ-027 ir and ir_pc SHALL stay stable while ir_valid=1 and ir_ready=0.
REQ-028 With a zero-wait memory and ir_ready=1, the block SHALL sustain one instruction per 2 cycles.
REQ-029 The first ir_valid SHALL rise 3 cycles after RST_N deasserts.
REQ-030 On redir_valid=1 the block SHALL, at the next edge, flush the buffer, set ir_valid=0, discard any partially fetched low byte, load the fetch address with redir_pc and enter FETCH_LO.
REQ-031 A mem_ack in the same cycle as redir_valid SHALL be discarded and SHALL NOT push.
REQ-032 redir_valid SHALL take priority over ir_ready; a pop in the redirect cycle SHALL still count as accepted by downstream.

Reset
REQ-033 While RST_N=0 the block SHALL immediately set: state=IDLE, fetch address=RESET_PC, count=0, mem_req=0, mem_addr=RESET_PC, ir_valid=0, ir=16'h0000, ir_pc=8'h00.
REQ-034 Reset asserted mid-fetch SHALL abandon the request without waiting for mem_ack.
REQ-035 The first mem_req SHALL rise in the first cycle after RST_N deasserts.

Verification
REQ-036 Bench SHALL cover: mem[0..7]=00,A1,02,23,01,C4,05,E6 with zero-wait memory and ir_ready=1 -> ir=A100, 2302, C401, E605 with ir_pc=0, 2, 4, 6, one instruction every 2 cycles.
REQ-037 Bench SHALL cover: ir_ready=0 from reset -> exactly 2 instructions buffered; mem_req stays 0; ir=A100 held stable; on releasing ir_ready, order is preserved.
REQ-038 Bench SHALL cover: redir_valid with redir_pc=8'h05 during FETCH_HI, with mem_ack in the same cycle -> no push; next outputs ir=0105 with ir_pc=5, then the next ir_pc=7.
REQ-039 Bench SHALL cover: redir_pc=8'hFF, mem[FF]=34, mem[00]=12 -> ir=1234 with ir_pc=FF; the next fetch starts at address 01.
REQ-040 Bench SHALL cover: 3 wait cycles per byte -> mem_addr stays stable and mem_req stays high until mem_ack; data is correct.
REQ-041 Bench SHALL cover: RST_N pulsed low while in FETCH_HI -> outputs take the REQ-033 values immediately; refetch begins at RESET_PC.

Source files
------------

// File: rtl/ifetch16_if.sv
// Fetch-unit bus: byte-wide instruction-memory port, redirect input and the
// instruction-register handshake towards decode.
interface ifetch16_if;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        redir_valid;
    logic [7:0]  redir_pc;
    logic        ir_valid;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_ready;

    modport master (
        output mem_req, mem_addr, ir_valid, ir, ir_pc,
        input  mem_ack, mem_rdata, redir_valid, redir_pc, ir_ready
    );

    modport slave (
        input  mem_req, mem_addr, ir_valid, ir, ir_pc,
        output mem_ack, mem_rdata, redir_valid, redir_pc, ir_ready
    );
endinterface

// File: rtl/ifetch16.sv
// 16-bit instruction fetch from a byte-wide memory: two byte reads per
// instruction feeding a 2-entry instruction buffer, with branch redirect.
module ifetch16 #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         DEPTH    = 2
) (
    input  logic       CK,
    input  logic       RST_N,
    ifetch16_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI} state_e;

    typedef struct packed {
        logic [15:0] ir;
        logic [7:0]  pc;
    } entry_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] lo_q, lo_d;
    logic [1:0] cnt_q, cnt_d;
    entry_t     head_q, tail_q, new_ent;
    logic       push, pop;

    assign pop  = (cnt_q != 2'd0) && bus.ir_ready;
    assign push = (state_q == FETCH_HI) && bus.mem_ack && !bus.redir_valid;

    // High byte arrives with the address already advanced past the low byte,
    // so the instruction PC is one behind (wraps naturally at 8 bits).
    assign new_ent = '{ir: {bus.mem_rdata, lo_q}, pc: addr_q - 8'd1};

    always_comb begin
        cnt_d = bus.redir_valid ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        if (bus.redir_valid) begin
            state_d = FETCH_LO;
            addr_d  = bus.redir_pc;
        end else begin
            unique case (state_q)
                IDLE: if (cnt_q < FULL) state_d = FETCH_LO;
                FETCH_LO: if (bus.mem_ack) begin
                    lo_d    = bus.mem_rdata;
                    addr_d  = addr_q + 8'd1;
                    state_d = FETCH_HI;
                end
                // Decide on the post-push count so a third push can never start.
                FETCH_HI: if (bus.mem_ack) begin
                    addr_d  = addr_q + 8'd1;
                    state_d = (cnt_d < FULL) ? FETCH_LO : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
            lo_q    <= 8'h00;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // head_q is always the oldest entry; a pop shifts tail into head.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (!bus.redir_valid) begin
            if (pop) head_q <= tail_q;
            if (push) begin
                if (cnt_q == {1'b0, pop}) head_q <= new_ent;
                else                      tail_q <= new_ent;
            end
        end
    end

    assign bus.mem_req  = (state_q == FETCH_LO) || (state_q == FETCH_HI);
    assign bus.mem_addr = addr_q;
    assign bus.ir_valid = (cnt_q != 2'd0);
    assign bus.ir       = head_q.ir;
    assign bus.ir_pc    = head_q.pc;

endmodule

// File: tb/tb_ifetch16.sv
// Self-checking bench for ifetch16: per-cycle vector table, directed corner
// sequences, then randomized traffic against an instruction-stream model.
module tb_ifetch16;
    logic CK = 1'b0;
    logic RST_N = 1'b0;

    ifetch16_if bus();

    ifetch16 #(.RESET_PC(8'h00), .DEPTH(2)) dut (
        .CK   (CK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CK = ~CK;

    // Memory model: ack after `waits` stalled cycles; `spur` drives ack while idle.
    logic [7:0] mem [256];
    int   waits = 0;
    int   wcnt;
    logic spur = 1'b0;

    assign bus.mem_ack   = bus.mem_req ? (wcnt >= waits) : spur;
    assign bus.mem_rdata = bus.mem_ack ? mem[bus.mem_addr] : 8'h00;

    always @(posedge CK or negedge RST_N) begin
        if (!RST_N)                            wcnt <= 0;
        else if (bus.mem_req && !bus.mem_ack)  wcnt <= wcnt + 1;
        else                                   wcnt <= 0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // A stalled request must hold address and stay asserted until acked.
    logic       p_wait = 1'b0;
    logic [7:0] p_addr = 8'h00;
    always @(negedge CK) begin
        #2;
        if (RST_N) begin
            if (p_wait) begin
                checks++;
                if (!bus.mem_req || bus.mem_addr !== p_addr) begin
                    errors++;
                    $display("FAIL req_hold: req=%0b addr=%0h expected req=1 addr=%0h",
                             bus.mem_req, bus.mem_addr, p_addr);
                end
            end
            p_wait = bus.mem_req && !bus.mem_ack && !bus.redir_valid;
            p_addr = bus.mem_addr;
        end else begin
            p_wait = 1'b0;
        end
    end

    task automatic do_reset();
        RST_N = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc = 8'h00;
        spur = 1'b0;
        repeat (2) @(negedge CK);
        @(posedge CK);
        #1 RST_N = 1'b1;
    endtask

    task automatic expect_accept(input logic [15:0] eir, input logic [7:0] epc,
                                 input string nm, input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge CK); #1;
            if (bus.ir_valid && bus.ir_ready) begin
                got = 1;
                chk({nm, "_ir"}, 32'(bus.ir), 32'(eir));
                chk({nm, "_pc"}, 32'(bus.ir_pc), 32'(epc));
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no transfer within %0d cycles, expected ir=%0h pc=%0h",
                     nm, budget, eir, epc);
        end else begin
            @(posedge CK);
        end
    endtask

    task automatic load_basic();
        logic [7:0] img [8];
        img = '{8'h00, 8'hA1, 8'h02, 8'h23, 8'h01, 8'hC4, 8'h05, 8'hE6};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5C);
        for (int i = 0; i < 8; i++) mem[i] = img[i];
    endtask

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [7:0]  exp_addr;
        logic        exp_valid;
        logic [15:0] exp_ir;
        logic [7:0]  exp_pc;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        bit   found;
        logic [7:0] exp_pc, nxt;
        int   n_xfer;

        // Zero-wait, always-ready: cycle index counts from reset release.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00};
        tbl[2] = '{1'b1, 1'b1, 8'h01, 1'b0, 16'h0000, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 8'h02, 1'b1, 16'hA100, 8'h00};
        tbl[4] = '{1'b1, 1'b1, 8'h03, 1'b0, 16'h0000, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 8'h04, 1'b1, 16'h2302, 8'h02};
        tbl[6] = '{1'b1, 1'b1, 8'h05, 1'b0, 16'h0000, 8'h00};
        tbl[7] = '{1'b1, 1'b1, 8'h06, 1'b1, 16'hC401, 8'h04};
        tbl[8] = '{1'b1, 1'b1, 8'h07, 1'b0, 16'h0000, 8'h00};
        tbl[9] = '{1'b1, 1'b1, 8'h08, 1'b1, 16'hE605, 8'h06};

        bus.ir_ready = 1'b1;
        bus.redir_valid = 1'b0;
        bus.redir_pc = 8'h00;
        load_basic();

        // Reset values while RST_N is held low
        @(negedge CK); #1;
        chk("rst_req",   32'(bus.mem_req),  32'd0);
        chk("rst_addr",  32'(bus.mem_addr), 32'h00);
        chk("rst_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_ir",    32'(bus.ir),       32'h0000);
        chk("rst_pc",    32'(bus.ir_pc),    32'h00);

        // Streaming at one instruction per two cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge CK); #1;
            bus.ir_ready = tbl[i].ready;
            #1;
            chk($sformatf("tbl%0d_req", i),   32'(bus.mem_req),  32'(tbl[i].exp_req));
            chk($sformatf("tbl%0d_addr", i),  32'(bus.mem_addr), 32'(tbl[i].exp_addr));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.ir_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_ir", i), 32'(bus.ir),    32'(tbl[i].exp_ir));
                chk($sformatf("tbl%0d_pc", i), 32'(bus.ir_pc), 32'(tbl[i].exp_pc));
            end
        end

        // Backpressure from reset: buffer fills to two, then fetch stops
        bus.ir_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge CK); #1;
            if (c >= 3) begin
                chk("bp_valid", 32'(bus.ir_valid), 32'd1);
                chk("bp_ir",    32'(bus.ir),       32'hA100);
                chk("bp_pc",    32'(bus.ir_pc),    32'h00);
            end
            if (c >= 5) chk("bp_req", 32'(bus.mem_req), 32'd0);
        end
        @(posedge CK); #1 bus.ir_ready = 1'b1;
        expect_accept(16'hA100, 8'h00, "bp_first", 1);
        expect_accept(16'h2302, 8'h02, "bp_second", 1);
        @(negedge CK); #1;
        chk("bp_empty", 32'(bus.ir_valid), 32'd0);
        expect_accept(16'hC401, 8'h04, "bp_third", 8);

        // Redirect to 05 in FETCH_HI with a coincident ack
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 1);
        mem[5] = 8'h05; mem[6] = 8'h01; mem[7] = 8'h77; mem[8] = 8'h88;
        do_reset();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CK); #1;
            if (bus.mem_req && bus.mem_addr == 8'h01 && bus.mem_ack) begin
                found = 1;
                bus.redir_valid = 1'b1;
                bus.redir_pc = 8'h05;
            end
        end
        chk("rd_found_hi", 32'(found), 32'd1);
        @(posedge CK); #1 bus.redir_valid = 1'b0;
        @(negedge CK); #1;
        chk("rd_flush_valid", 32'(bus.ir_valid), 32'd0);
        chk("rd_new_addr",    32'(bus.mem_addr), 32'h05);
        chk("rd_new_req",     32'(bus.mem_req),  32'd1);
        expect_accept(16'h0105, 8'h05, "rd_first", 6);
        expect_accept(16'h8877, 8'h07, "rd_second", 6);

        // Redirect to FF: instruction straddles the address wrap
        mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12; mem[8'h01] = 8'h5A; mem[8'h02] = 8'hC3;
        do_reset();
        @(negedge CK); #1;
        bus.redir_valid = 1'b1;
        bus.redir_pc = 8'hFF;
        @(posedge CK); #1 bus.redir_valid = 1'b0;
        @(negedge CK); #1 chk("wrap_addr_ff", 32'(bus.mem_addr), 32'hFF);
        @(negedge CK); #1 chk("wrap_addr_00", 32'(bus.mem_addr), 32'h00);
        @(negedge CK); #1;
        chk("wrap_addr_01", 32'(bus.mem_addr), 32'h01);
        chk("wrap_valid",   32'(bus.ir_valid), 32'd1);
        chk("wrap_ir",      32'(bus.ir),       32'h1234);
        chk("wrap_pc",      32'(bus.ir_pc),    32'hFF);
        @(posedge CK);
        expect_accept(16'hC35A, 8'h01, "wrap_next", 8);

        // Three wait cycles per byte
        load_basic();
        waits = 3;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge CK); #1;
            if (c >= 1) begin
                chk("ws_req",  32'(bus.mem_req),  32'd1);
                chk("ws_addr", 32'(bus.mem_addr), 32'h00);
                chk("ws_ack",  32'(bus.mem_ack),  32'(c == 4));
            end
        end
        expect_accept(16'hA100, 8'h00, "ws_i0", 20);
        expect_accept(16'h2302, 8'h02, "ws_i1", 20);
        expect_accept(16'hC401, 8'h04, "ws_i2", 20);

        // Reset pulsed mid FETCH_HI of the second instruction
        bus.ir_ready = 1'b0;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CK); #1;
            if (bus.mem_req && bus.mem_addr == 8'h03) found = 1;
        end
        chk("mr_found_hi", 32'(found), 32'd1);
        chk("mr_pre_ir",   32'(bus.ir), 32'hA100);
        RST_N = 1'b0;
        #1;
        chk("mr_req",   32'(bus.mem_req),  32'd0);
        chk("mr_addr",  32'(bus.mem_addr), 32'h00);
        chk("mr_valid", 32'(bus.ir_valid), 32'd0);
        chk("mr_ir",    32'(bus.ir),       32'h0000);
        chk("mr_pc",    32'(bus.ir_pc),    32'h00);
        waits = 0;
        bus.ir_ready = 1'b1;
        do_reset();
        @(negedge CK); #1 chk("mr_c0_req", 32'(bus.mem_req), 32'd0);
        @(negedge CK); #1;
        chk("mr_c1_req",  32'(bus.mem_req),  32'd1);
        chk("mr_c1_addr", 32'(bus.mem_addr), 32'h00);
        @(posedge CK);
        expect_accept(16'hA100, 8'h00, "mr_refetch", 6);

        // Randomized traffic: every accepted word must be the next sequential
        // instruction of the current stream; a redirect restarts the stream.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        exp_pc = 8'h00;
        n_xfer = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CK); #1;
            bus.ir_ready    = ($urandom % 4) != 0;
            bus.redir_valid = ($urandom % 25) == 0;
            bus.redir_pc    = 8'($urandom);
            waits           = int'($urandom_range(0, 2));
            spur            = 1'($urandom);
            #1;
            if (bus.ir_valid && bus.ir_ready) begin
                nxt = exp_pc + 8'd1;
                chk("rand_ir", 32'(bus.ir),    32'({mem[nxt], mem[exp_pc]}));
                chk("rand_pc", 32'(bus.ir_pc), 32'(exp_pc));
                exp_pc = exp_pc + 8'd2;
                n_xfer++;
            end
            if (bus.redir_valid) exp_pc = bus.redir_pc;
        end
        chk("rand_enough_xfers", 32'(n_xfer > 200), 32'd1);
        bus.redir_valid = 1'b0;
        spur = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
